mem_portb_arbiter: RTL and testbench
====================================

// Module: mem_portb_arbiter
// PURPOSE
//  Shares port B of the 16-bit block data memory between two requesters:
//  req 0 = CPU control unit (stack/data accesses), req 1 = debug/loader port.
//  Round-robin arbitration; one transaction in flight; registered memory-side outputs.
//  Sits between the control/datapath and the block RAM. Memory port A (fetch) is untouched.
// PARAMETERS
//  ADDR_W     16    requester/memory address width (word address)
//  DATA_W     16    data word width
//  MEM_WORDS  1280  implemented memory depth in words (20480 bits / 16)
// PORTS
//  CLK        in   1       system clock, all logic on rising edge
//  CtrlRst    in   1       reset; synchronous, active-low
//  Req[1:0]   in   2       per-requester request level; held until its Ack
//  We[1:0]    in   2       per-requester write enable (1=write, 0=read)
//  Addr0/1    in   ADDR_W  per-requester word address
//  WrData0/1  in   DATA_W  per-requester write data
//  Ack[1:0]   out  2       one-cycle completion pulse to the granted requester
//  RdData     out  DATA_W  read data; valid only while the Ack bit is high
//  Busy       out  1       high in any state other than IDLE
//  Err        out  1       bounds error, pulses with Ack (only with ARB_BOUNDS_CHECK_EN)
//  MemAddr    out  ADDR_W  port B address (registered)
//  MemWe      out  1       port B write enable (registered)
//  MemDin     out  DATA_W  port B write data (registered)
//  MemDout    in   DATA_W  port B read data; valid 1 cycle after the address edge
// BEHAVIOUR
//  Reset (CtrlRst==0 at edge): state=IDLE, Ack=0, RdData=0, Busy=0, Err=0,
//   MemAddr=0, MemWe=0, MemDin=0, LastGnt=1 (CPU wins the first tie).
//  FSM: IDLE -> ACCESS -> (read: WAIT ->) DONE -> IDLE.
//  IDLE: if any Req is high, pick the winner, latch its We/Addr/WrData, go to ACCESS.
//   Tie: grant the requester != LastGnt. Update LastGnt on each grant.
//  ACCESS: exactly 1 cycle. Mem* driven; MemWe=1 only for a write.
//   Read -> WAIT. Write -> DONE.
//  WAIT: MemDout is valid; register it into RdData; go to DONE.
//  DONE: Ack[gnt]=1 for this single cycle. MemWe=0. Return to IDLE.
//  Latency from the IDLE sample cycle to the Ack cycle: write = 2, read = 3.
//  Handshake:
//   - The requester holds Req/We/Addr/WrData stable through its DONE cycle.
//   - It drops Req at the edge that ends DONE.
//   - A Req still high in the following IDLE cycle is a new transaction.
//  Changes on the non-granted requester's inputs are ignored until the next IDLE.
//  Ack is never high for both bits at once. RdData holds its value after a write.
//  Reset mid-operation:
//   - No Ack for the aborted transaction; the FSM returns to IDLE.
//   - A write whose ACCESS cycle ends on the reset edge is committed to memory;
//     the requester must retry.
//  Reset is asserted (CtrlRst==0) for at least 3 CLK edges at power-up, then released.
// CONFIGURATION
//  ARB_BOUNDS_CHECK_EN defined:
//   - Addr >= MEM_WORDS is flagged at the IDLE latch.
//   - ACCESS keeps MemWe=0; the FSM goes straight to DONE with RdData=0 and Err=1 alongside Ack.
//  Not defined:
//   - Err is tied to 0.
//   - The address passes unchanged; out-of-range behaviour is the memory's.
// STRUCTURE
//  Package jala_mem_pkg:
//   - ADDR_W/DATA_W/MEM_WORDS defaults
//   - FSM state encoding (IDLE, ACCESS, WAIT, DONE; 2 bits)
//   - requester IDs REQ_CPU=0, REQ_DBG=1
//  Sub-module rr_arb2: a combinational 2-way round-robin pick (Req, LastGnt -> GntId, GntValid).
//   The FSM, latches and memory registers stay in mem_portb_arbiter.
// TESTING
//  1. Reset: CtrlRst=0 for 3 edges, Req=2'b11 -> Ack=0, MemWe=0, Busy=0, no grant.
//  2. CPU write Addr0=0x0123 WrData0=0xBEEF -> MemWe high exactly 1 cycle, Ack[0] 2 cycles after the sample.
//     Then CPU read 0x0123 -> Ack[0] 3 cycles after the sample with RdData=0xBEEF.
//  3. Req=2'b11 right after reset -> CPU served first, then debug.
//     Repeat the tie -> the grant order alternates.
//  4. Both Req held continuously for 8 reads -> Ack order 0,1,0,1,... with no gaps.
//     Each RdData matches the preloaded memory word.
//  5. CtrlRst=0 during WAIT of a debug read -> no Ack[1], Busy=0 next cycle.
//     A new debug read completes normally.
//  6. With ARB_BOUNDS_CHECK_EN: write to 0x0500 -> MemWe stays 0; Ack[0] with Err=1, RdData=0.
//     Without it: MemAddr=0x0500 and MemWe pulses.

Source files
------------

// File: rtl/jala_mem_pkg.sv
// Shared definitions for the port-B arbiter of the 16-bit block data memory.
// Holds default widths, the FSM state encoding and the requester IDs.
package jala_mem_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_WORDS = 1280;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_portb_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a tie goes to the requester that
// did not win the previous grant.
module rr_arb2
    import jala_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = REQ_CPU;
        case (req_i)
            2'b10:   gnt_id_o = REQ_DBG;
            2'b11:   gnt_id_o = ~last_gnt_i;
            default: gnt_id_o = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/mem_portb_arbiter.sv
// Port-B arbiter between the CPU control unit and the debug/loader port.
// Optional bounds checking is enabled by defining ARB_BOUNDS_CHECK_EN.
//
//   state  | meaning
//   IDLE   | waiting for a request; latches the winner's command
//   ACCESS | memory outputs presented for one cycle
//   WAIT   | read data returning from the RAM, captured into RdData
//   DONE   | Ack (and Err) pulse to the granted requester
module mem_portb_arbiter
    import jala_mem_pkg::*;
#(
    parameter int ADDR_W    = jala_mem_pkg::ADDR_W,
    parameter int DATA_W    = jala_mem_pkg::DATA_W,
    parameter int MEM_WORDS = jala_mem_pkg::MEM_WORDS
) (
    input  logic              CLK,
    input  logic              CtrlRst,
    input  logic [1:0]        Req,
    input  logic [1:0]        We,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WrData0,
    input  logic [DATA_W-1:0] WrData1,
    output logic [1:0]        Ack,
    output logic [DATA_W-1:0] RdData,
    output logic              Busy,
    output logic              Err,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemDin,
    input  logic [DATA_W-1:0] MemDout
);

`ifdef ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic              oob_q, oob_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        ack_q, ack_d;
    logic              err_q, err_d;

    logic              pick_id;
    logic              pick_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    rr_arb2 u_rr_arb2 (
        .req_i       (Req),
        .last_gnt_i  (last_gnt_q),
        .gnt_id_o    (pick_id),
        .gnt_valid_o (pick_valid)
    );

    assign sel_addr  = pick_id ? Addr1 : Addr0;
    assign sel_wdata = pick_id ? WrData1 : WrData0;
    assign sel_we    = We[pick_id];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        oob_d      = oob_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        rd_data_d  = rd_data_q;
        ack_d      = 2'b00;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = ACCESS;
                    gnt_d      = pick_id;
                    last_gnt_d = pick_id;
                    we_d       = sel_we;
                    oob_d      = BOUNDS_EN && (sel_addr >= ADDR_W'(MEM_WORDS));
                    mem_addr_d = sel_addr;
                    mem_din_d  = sel_wdata;
                    mem_we_d   = sel_we && !oob_d;
                end
            end
            ACCESS: begin
                if (oob_q) begin
                    // Out-of-range access skips the RAM entirely and reports zero data.
                    state_d       = DONE;
                    rd_data_d     = '0;
                    ack_d[gnt_q]  = 1'b1;
                    err_d         = 1'b1;
                end else if (we_q) begin
                    state_d       = DONE;
                    ack_d[gnt_q]  = 1'b1;
                end else begin
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                rd_data_d    = MemDout;
                ack_d[gnt_q] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CtrlRst) begin
            state_q    <= IDLE;
            gnt_q      <= REQ_CPU;
            last_gnt_q <= REQ_DBG;
            we_q       <= 1'b0;
            oob_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            rd_data_q  <= '0;
            ack_q      <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            oob_q      <= oob_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            rd_data_q  <= rd_data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign Ack     = ack_q;
    assign RdData  = rd_data_q;
    assign Busy    = (state_q != IDLE);
    assign Err     = err_q;
    assign MemAddr = mem_addr_q;
    assign MemWe   = mem_we_q;
    assign MemDin  = mem_din_q;

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Scoreboard bench for mem_portb_arbiter: directed handshake/arbitration cases
// followed by randomized concurrent traffic from both requesters.
module tb_mem_portb_arbiter;
    import jala_mem_pkg::*;

`ifdef ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        logic        chk_rd;
        logic [15:0] data;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        CtrlRst;
    logic [1:0]  Req, We;
    logic [15:0] Addr0, Addr1, WrData0, WrData1;
    logic [1:0]  Ack;
    logic [15:0] RdData;
    logic        Busy, Err;
    logic [15:0] MemAddr, MemDin, MemDout;
    logic        MemWe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q_cpu[$];
    exp_t q_dbg[$];
    int ack_who[$];
    int ack_when[$];
    int we_pulses = 0;
    logic [15:0] we_addr = 16'h0;
    logic [15:0] last_rd = 16'h0;
    logic [15:0] mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit mem_init = 1'b0;

    mem_portb_arbiter dut (
        .CLK     (CLK),
        .CtrlRst (CtrlRst),
        .Req     (Req),
        .We      (We),
        .Addr0   (Addr0),
        .Addr1   (Addr1),
        .WrData0 (WrData0),
        .WrData1 (WrData1),
        .Ack     (Ack),
        .RdData  (RdData),
        .Busy    (Busy),
        .Err     (Err),
        .MemAddr (MemAddr),
        .MemWe   (MemWe),
        .MemDin  (MemDin),
        .MemDout (MemDout)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] preload(input int a);
        logic [31:0] v;
        v = a * 37 + 4096;
        return v[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic oob(input logic [15:0] a);
        return BOUNDS && (a >= 16'd1280);
    endfunction

    // Synchronous RAM, read-first, data one cycle after the address edge.
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= preload(i);
            mem_init <= 1'b1;
        end else begin
            if (MemWe) mem[MemAddr] <= MemDin;
            MemDout <= mem[MemAddr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever an Ack appears.
    initial begin
        forever begin
            int   r;
            exp_t e;
            bit   got;
            @(posedge CLK); #1;
            if (MemWe === 1'b1) begin
                we_pulses++;
                we_addr = MemAddr;
            end
            if (Ack !== 2'b00) begin
                check("ack_onehot", 32'((Ack == 2'b01) || (Ack == 2'b10)), 32'd1);
                r = Ack[1] ? 1 : 0;
                ack_who.push_back(r);
                ack_when.push_back(cyc);
                got = 1'b0;
                if (r == 0 && q_cpu.size() > 0) begin
                    e = q_cpu.pop_front(); got = 1'b1;
                end else if (r == 1 && q_dbg.size() > 0) begin
                    e = q_dbg.pop_front(); got = 1'b1;
                end
                if (!got) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: Ack=%b with no outstanding request (cycle %0d)", Ack, cyc);
                end else begin
                    if (e.chk_rd) begin
                        check(r ? "rd_data_dbg" : "rd_data_cpu", 32'(RdData), 32'(e.data));
                        last_rd = e.data;
                    end else begin
                        check("rd_hold_after_write", 32'(RdData), 32'(last_rd));
                    end
                    check("err", 32'(Err), 32'(e.err));
                    if (e.lat >= 0) check("latency", 32'(cyc - e.issue), 32'(e.lat));
                end
            end
        end
    end

    // Issue one transaction at #1 after an edge; returns #1 after the edge ending DONE, Req still high.
    task automatic drive(input int r, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input int lat);
        exp_t e;
        int   n;
        Req[r] = 1'b1;
        We[r]  = w;
        if (r == 0) begin Addr0 = a; WrData0 = d; end
        else        begin Addr1 = a; WrData1 = d; end
        e.err    = oob(a);
        e.chk_rd = !w || e.err;
        e.data   = e.err ? 16'h0 : (w ? d : ref_mem[a]);
        e.issue  = cyc;
        e.lat    = lat;
        if (w && !e.err) ref_mem[a] = d;
        if (r == 0) q_cpu.push_back(e); else q_dbg.push_back(e);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (Ack[r] !== 1'b1 && n < 200);
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL ack_timeout: requester %0d got no Ack within 200 cycles", r);
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(input int edges);
        CtrlRst = 1'b0;
        Req     = 2'b11;
        We      = 2'b00;
        repeat (edges) begin
            @(posedge CLK); #1;
            check("rst_ack", 32'(Ack), 32'd0);
            check("rst_memwe", 32'(MemWe), 32'd0);
            check("rst_busy", 32'(Busy), 32'd0);
        end
        check("rst_rddata", 32'(RdData), 32'd0);
        check("rst_memaddr", 32'(MemAddr), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        q_cpu.delete();
        q_dbg.delete();
        last_rd = 16'h0;
        Req     = 2'b00;
        CtrlRst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int first;
        Req = 2'b00; We = 2'b00;
        Addr0 = 16'h0; Addr1 = 16'h0; WrData0 = 16'h0; WrData1 = 16'h0;
        CtrlRst = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = preload(i);

        // Power-up reset with both requests asserted, then a CPU write/read pair.
        do_reset(3);
        we_pulses = 0;
        drive(0, 1'b1, 16'h0123, 16'hBEEF, 2); Req[0] = 1'b0;
        check("t2_we_pulses", 32'(we_pulses), 32'd1);
        check("t2_we_addr", 32'(we_addr), 32'h0123);
        drive(0, 1'b0, 16'h0123, 16'h0000, 3); Req[0] = 1'b0;
        check("t2_last_rd", 32'(last_rd), 32'hBEEF);

        // Tie right after reset: CPU first; repeated tie keeps alternating overall.
        do_reset(3);
        n0 = ack_who.size();
        fork
            begin drive(0, 1'b0, 16'h0010, 16'h0, -1); Req[0] = 1'b0; end
            begin drive(1, 1'b0, 16'h0210, 16'h0, -1); Req[1] = 1'b0; end
        join
        check("t3_tie1_first", 32'(ack_who[n0]), 32'd0);
        check("t3_tie1_second", 32'(ack_who[n0+1]), 32'd1);
        n0 = ack_who.size();
        fork
            begin drive(0, 1'b0, 16'h0011, 16'h0, -1); Req[0] = 1'b0; end
            begin drive(1, 1'b0, 16'h0211, 16'h0, -1); Req[1] = 1'b0; end
        join
        check("t3_tie2_first", 32'(ack_who[n0]), 32'd0);
        check("t3_tie2_second", 32'(ack_who[n0+1]), 32'd1);
        drive(0, 1'b1, 16'h0012, 16'h55AA, 2); Req[0] = 1'b0;
        n0 = ack_who.size();
        fork
            begin drive(0, 1'b0, 16'h0012, 16'h0, -1); Req[0] = 1'b0; end
            begin drive(1, 1'b0, 16'h0212, 16'h0, -1); Req[1] = 1'b0; end
        join
        check("t3_tie3_first", 32'(ack_who[n0]), 32'd1);
        check("t3_tie3_second", 32'(ack_who[n0+1]), 32'd0);

        // Both held continuously for 8 reads: strict alternation, one Ack every 4 cycles.
        first = 1 - ack_who[ack_who.size()-1];
        n0 = ack_who.size();
        fork
            begin
                for (int k = 0; k < 4; k++) drive(0, 1'b0, 16'(16'h0020 + k), 16'h0, -1);
                Req[0] = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) drive(1, 1'b0, 16'(16'h0220 + k), 16'h0, -1);
                Req[1] = 1'b0;
            end
        join
        for (int i = 0; i < 8; i++) begin
            check("t4_order", 32'(ack_who[n0+i]), 32'((first + i) % 2));
            if (i > 0) check("t4_spacing", 32'(ack_when[n0+i] - ack_when[n0+i-1]), 32'd4);
        end

        // Reset during WAIT of a debug read aborts it without an Ack.
        n0 = ack_who.size();
        Req[1] = 1'b1; We[1] = 1'b0; Addr1 = 16'h0230;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("t5_busy_in_wait", 32'(Busy), 32'd1);
        CtrlRst = 1'b0; Req[1] = 1'b0;
        @(posedge CLK); #1;
        check("t5_busy_after_rst", 32'(Busy), 32'd0);
        check("t5_ack_after_rst", 32'(Ack), 32'd0);
        check("t5_rddata_after_rst", 32'(RdData), 32'd0);
        CtrlRst = 1'b1;
        last_rd = 16'h0;
        repeat (3) begin @(posedge CLK); #1; end
        check("t5_no_ack", 32'(ack_who.size()), 32'(n0));
        drive(1, 1'b0, 16'h0230, 16'h0, 3); Req[1] = 1'b0;

        // Write to 0x0500: rejected with Err under bounds checking, passed through otherwise.
        we_pulses = 0;
        drive(0, 1'b1, 16'h0500, 16'h1234, 2); Req[0] = 1'b0;
        if (BOUNDS) begin
            check("t6_we_suppressed", 32'(we_pulses), 32'd0);
        end else begin
            check("t6_we_pulse", 32'(we_pulses), 32'd1);
            check("t6_we_addr", 32'(we_addr), 32'h0500);
        end

        // Random concurrent traffic; each requester owns a disjoint address window.
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    int gap;
                    drive(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
                          16'($urandom), -1);
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        Req[0] = 1'b0;
                        repeat (gap) begin @(posedge CLK); #1; end
                    end
                end
                Req[0] = 1'b0;
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    int gap;
                    drive(1, 1'($urandom_range(0, 1)), 16'(16'h0200 + $urandom_range(0, 255)),
                          16'($urandom), -1);
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        Req[1] = 1'b0;
                        repeat (gap) begin @(posedge CLK); #1; end
                    end
                end
                Req[1] = 1'b0;
            end
        join

        repeat (4) begin @(posedge CLK); #1; end
        check("q_cpu_drained", 32'(q_cpu.size()), 32'd0);
        check("q_dbg_drained", 32'(q_dbg.size()), 32'd0);
        check("idle_at_end", 32'(Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
